// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset driver, lock debouncer and staggered release of NUM_DOMAINS reset domains.
// Lock loss pulls every domain back into reset and is counted in a saturating counter.
module pll_lock_reset_sequencer #(
    parameter int NUM_DOMAINS        = 3,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 64,
    parameter int SYNC_STAGES        = 2,
    parameter int AUTO_PLL_RESET     = 1,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   soft_reset,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_ready,
    output logic [LOSS_CNT_W-1:0]  loss_count,
    output logic [1:0]             seq_state
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int RST_W     = $clog2(PLL_RST_CYCLES + 1);
    localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int STAGE_MAX = (NUM_DOMAINS - 1) * STAGE_DELAY;
    localparam int STAGE_W   = (STAGE_MAX < 1) ? 1 : $clog2(STAGE_MAX + 1);

    localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     lock_s;
    logic [RST_W-1:0]         rst_cnt;
    logic [STABLE_W-1:0]      stable_cnt;
    logic [STAGE_W-1:0]       stage_cnt;
    logic [STAGE_W-1:0]       stage_next;
    logic [NUM_DOMAINS-1:0]   release_mask;
    logic                     last_stage;
    logic                     loss_event;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s     = sync_q[SYNC_STAGES-1];
    assign seq_state  = state;
    assign loss_event = !lock_s && (state == ST_RELEASE || state == ST_RUN);

    // Domain i is released on the edge where the stage counter reaches i*STAGE_DELAY.
    always_comb begin
        stage_next   = stage_cnt + STAGE_W'(1);
        release_mask = '0;
        for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (int'(stage_next) == i * STAGE_DELAY) begin
                release_mask[i] = 1'b1;
            end
        end
        last_stage = (int'(stage_next) == STAGE_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_PLL_RST;
            pll_rst        <= 1'b1;
            domain_reset_n <= '0;
            all_ready      <= 1'b0;
            loss_count     <= '0;
            rst_cnt        <= '0;
            stable_cnt     <= '0;
            stage_cnt      <= '0;
        end else begin
            if (loss_event && loss_count != '1) begin
                loss_count <= loss_count + LOSS_CNT_W'(1);
            end

            // soft_reset takes precedence over the loss transition; the loss is still counted above.
            if (soft_reset || loss_event) begin
                domain_reset_n <= '0;
                all_ready      <= 1'b0;
                rst_cnt        <= '0;
                stable_cnt     <= '0;
                stage_cnt      <= '0;
                if (soft_reset || AUTO_PLL_RESET != 0) begin
                    state   <= ST_PLL_RST;
                    pll_rst <= 1'b1;
                end else begin
                    state <= ST_WAIT_LOCK;
                end
            end else begin
                case (state)
                    ST_PLL_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            pll_rst    <= 1'b0;
                            stable_cnt <= '0;
                            state      <= ST_WAIT_LOCK;
                        end else begin
                            rst_cnt <= rst_cnt + RST_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (!lock_s) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt == STABLE_LAST) begin
                            domain_reset_n[0] <= 1'b1;
                            stage_cnt         <= '0;
                            if (NUM_DOMAINS == 1) begin
                                all_ready <= 1'b1;
                                state     <= ST_RUN;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            stable_cnt <= stable_cnt + STABLE_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        stage_cnt      <= stage_next;
                        domain_reset_n <= domain_reset_n | release_mask;
                        if (last_stage) begin
                            all_ready <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench: dut_a auto-resets the PLL on lock loss (8-bit counter), dut_b waits for relock (2-bit counter).
// Snapshots are packed as {pll_rst, domain_reset_n[2:0], all_ready, seq_state[1:0]}.
module tb_pll_lock_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset;

    logic       a_pll_rst;
    logic [2:0] a_dom;
    logic       a_ready;
    logic [7:0] a_loss;
    logic [1:0] a_state;

    logic       b_pll_rst;
    logic [2:0] b_dom;
    logic       b_ready;
    logic [1:0] b_loss;
    logic [1:0] b_state;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] S_RST  = 7'b1_000_0_00;
    localparam logic [6:0] S_WAIT = 7'b0_000_0_01;
    localparam logic [6:0] S_R001 = 7'b0_001_0_10;
    localparam logic [6:0] S_R011 = 7'b0_011_0_10;
    localparam logic [6:0] S_RUN  = 7'b0_111_1_11;

    pll_lock_reset_sequencer #(
        .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .STAGE_DELAY(4),
        .SYNC_STAGES(2), .AUTO_PLL_RESET(1), .LOSS_CNT_W(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
        .pll_rst(a_pll_rst), .domain_reset_n(a_dom), .all_ready(a_ready),
        .loss_count(a_loss), .seq_state(a_state)
    );

    pll_lock_reset_sequencer #(
        .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .STAGE_DELAY(4),
        .SYNC_STAGES(2), .AUTO_PLL_RESET(0), .LOSS_CNT_W(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
        .pll_rst(b_pll_rst), .domain_reset_n(b_dom), .all_ready(b_ready),
        .loss_count(b_loss), .seq_state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] snap_a();
        return {a_pll_rst, a_dom, a_ready, a_state};
    endfunction

    function automatic logic [6:0] snap_b();
        return {b_pll_rst, b_dom, b_ready, b_state};
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after an edge; the next rising edge is edge 1.
    task automatic do_reset(input logic lk);
        reset_n    = 1'b0;
        soft_reset = 1'b0;
        pll_locked = lk;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        soft_reset = 1'b0;
        pll_locked = 1'b1;
        tick(2);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL reset_a got=%b exp=%b", snap_a(), S_RST); end
        n_cmp++;
        if (snap_b() !== S_RST) begin n_bad++; $display("FAIL reset_b got=%b exp=%b", snap_b(), S_RST); end
        n_cmp++;
        if ({a_loss, b_loss} !== 10'd0) begin n_bad++; $display("FAIL reset_loss got=%h/%h exp=0/0", a_loss, b_loss); end
        reset_n = 1'b1;
    endtask

    task automatic test_cold_start();
        tick(3);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL cold_edge3 got=%b exp=%b", snap_a(), S_RST); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_WAIT) begin n_bad++; $display("FAIL cold_edge4 got=%b exp=%b", snap_a(), S_WAIT); end
        tick(7);
        n_cmp++;
        if (snap_a() !== S_WAIT) begin n_bad++; $display("FAIL cold_edge11 got=%b exp=%b", snap_a(), S_WAIT); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_R001) begin n_bad++; $display("FAIL cold_edge12 got=%b exp=%b", snap_a(), S_R001); end
        tick(3);
        n_cmp++;
        if (snap_a() !== S_R001) begin n_bad++; $display("FAIL cold_edge15 got=%b exp=%b", snap_a(), S_R001); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_R011) begin n_bad++; $display("FAIL cold_edge16 got=%b exp=%b", snap_a(), S_R011); end
        tick(3);
        n_cmp++;
        if (snap_a() !== S_R011) begin n_bad++; $display("FAIL cold_edge19 got=%b exp=%b", snap_a(), S_R011); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_RUN) begin n_bad++; $display("FAIL cold_edge20_a got=%b exp=%b", snap_a(), S_RUN); end
        n_cmp++;
        if (snap_b() !== S_RUN) begin n_bad++; $display("FAIL cold_edge20_b got=%b exp=%b", snap_b(), S_RUN); end
    endtask

    // lock_s is low only in the cycle after edge 10 (stable count 6); the count restarts from 0
    // at edge 11, so release moves from edge 12 to edge 19.
    task automatic test_lock_glitch();
        do_reset(1'b1);
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(3);
        n_cmp++;
        if (snap_a() !== S_WAIT) begin n_bad++; $display("FAIL glitch_edge12 got=%b exp=%b", snap_a(), S_WAIT); end
        tick(6);
        n_cmp++;
        if (snap_a() !== S_WAIT) begin n_bad++; $display("FAIL glitch_edge18 got=%b exp=%b", snap_a(), S_WAIT); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_R001) begin n_bad++; $display("FAIL glitch_edge19_a got=%b exp=%b", snap_a(), S_R001); end
        n_cmp++;
        if (snap_b() !== S_R001) begin n_bad++; $display("FAIL glitch_edge19_b got=%b exp=%b", snap_b(), S_R001); end
        n_cmp++;
        if (a_loss !== 8'd0) begin n_bad++; $display("FAIL glitch_loss got=%0d exp=0", a_loss); end
    endtask

    // pll_locked drops after edge 20; lock_s falls after edge 22; loss acted on at edge 23.
    task automatic test_lock_loss_run();
        do_reset(1'b1);
        tick(20);
        pll_locked = 1'b0;
        tick(2);
        n_cmp++;
        if (snap_a() !== S_RUN) begin n_bad++; $display("FAIL loss_edge22 got=%b exp=%b", snap_a(), S_RUN); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL loss_edge23_a got=%b exp=%b", snap_a(), S_RST); end
        n_cmp++;
        if (snap_b() !== S_WAIT) begin n_bad++; $display("FAIL loss_edge23_b got=%b exp=%b", snap_b(), S_WAIT); end
        n_cmp++;
        if (a_loss !== 8'd1 || b_loss !== 2'd1) begin
            n_bad++; $display("FAIL loss_count_first got=%0d/%0d exp=1/1", a_loss, b_loss);
        end
        tick(3);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL loss_edge26_a got=%b exp=%b", snap_a(), S_RST); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_WAIT) begin n_bad++; $display("FAIL loss_edge27_a got=%b exp=%b", snap_a(), S_WAIT); end
        n_cmp++;
        if (snap_b() !== S_WAIT) begin n_bad++; $display("FAIL loss_edge27_b got=%b exp=%b", snap_b(), S_WAIT); end
        pll_locked = 1'b1;
        tick(9);
        n_cmp++;
        if ({snap_a(), snap_b()} !== {S_WAIT, S_WAIT}) begin
            n_bad++; $display("FAIL relock_edge36 got=%b/%b exp=%b", snap_a(), snap_b(), S_WAIT);
        end
        tick(1);
        n_cmp++;
        if ({snap_a(), snap_b()} !== {S_R001, S_R001}) begin
            n_bad++; $display("FAIL relock_edge37 got=%b/%b exp=%b", snap_a(), snap_b(), S_R001);
        end
        tick(4);
        n_cmp++;
        if ({snap_a(), snap_b()} !== {S_R011, S_R011}) begin
            n_bad++; $display("FAIL relock_edge41 got=%b/%b exp=%b", snap_a(), snap_b(), S_R011);
        end
        tick(4);
        n_cmp++;
        if ({snap_a(), snap_b()} !== {S_RUN, S_RUN}) begin
            n_bad++; $display("FAIL relock_edge45 got=%b/%b exp=%b", snap_a(), snap_b(), S_RUN);
        end
        n_cmp++;
        if (a_loss !== 8'd1) begin n_bad++; $display("FAIL relock_loss got=%0d exp=1", a_loss); end
    endtask

    // dut_b: each loss lands 3 edges after the drop, RUN again 18 edges after relock.
    task automatic test_loss_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset(1'b1);
        tick(20);
        for (int k = 0; k < 5; k++) begin
            pll_locked = 1'b0;
            tick(3);
            n_cmp++;
            if (b_loss !== exp_cnt[k] || b_state !== 2'd1) begin
                n_bad++; $display("FAIL sat_loss%0d got=%0d st=%0d exp=%0d st=1", k, b_loss, b_state, exp_cnt[k]);
            end
            pll_locked = 1'b1;
            tick(18);
            n_cmp++;
            if (snap_b() !== S_RUN) begin n_bad++; $display("FAIL sat_run%0d got=%b exp=%b", k, snap_b(), S_RUN); end
        end
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        n_cmp++;
        if (snap_b() !== S_RST || b_loss !== 2'd3) begin
            n_bad++; $display("FAIL soft_run got=%b loss=%0d exp=%b loss=3", snap_b(), b_loss, S_RST);
        end
    endtask

    // lock_s low from edge 17 and soft_reset sampled at edge 18 while at 011.
    task automatic test_soft_reset_release();
        do_reset(1'b1);
        tick(15);
        pll_locked = 1'b0;
        tick(2);
        n_cmp++;
        if (snap_a() !== S_R011) begin n_bad++; $display("FAIL soft_edge17 got=%b exp=%b", snap_a(), S_R011); end
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        n_cmp++;
        if (snap_a() !== S_RST || a_loss !== 8'd1) begin
            n_bad++; $display("FAIL soft_edge18_a got=%b loss=%0d exp=%b loss=1", snap_a(), a_loss, S_RST);
        end
        n_cmp++;
        if (snap_b() !== S_RST || b_loss !== 2'd1) begin
            n_bad++; $display("FAIL soft_edge18_b got=%b loss=%0d exp=%b loss=1", snap_b(), b_loss, S_RST);
        end
        tick(2);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        tick(1);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL soft_restart_edge22 got=%b exp=%b", snap_a(), S_RST); end
        tick(2);
        n_cmp++;
        if (snap_a() !== S_RST) begin n_bad++; $display("FAIL soft_restart_edge24 got=%b exp=%b", snap_a(), S_RST); end
        tick(1);
        n_cmp++;
        if (snap_a() !== S_WAIT || a_loss !== 8'd1) begin
            n_bad++; $display("FAIL soft_restart_edge25 got=%b loss=%0d exp=%b loss=1", snap_a(), a_loss, S_WAIT);
        end
        pll_locked = 1'b1;
        tick(11);
        n_cmp++;
        if (snap_a() !== S_R001) begin n_bad++; $display("FAIL soft_edge36 got=%b exp=%b", snap_a(), S_R001); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (snap_a() !== S_RST || a_loss !== 8'd0) begin
            n_bad++; $display("FAIL async_reset_a got=%b loss=%0d exp=%b loss=0", snap_a(), a_loss, S_RST);
        end
        n_cmp++;
        if (snap_b() !== S_RST || b_loss !== 2'd0) begin
            n_bad++; $display("FAIL async_reset_b got=%b loss=%0d exp=%b loss=0", snap_b(), b_loss, S_RST);
        end
        tick(1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        soft_reset = 1'b0;
        test_reset();
        test_cold_start();
        test_lock_glitch();
        test_lock_loss_run();
        test_loss_saturation();
        test_soft_reset_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
